ahb_arbiter: RTL and testbench
==============================

Name: ahb_arbiter

Overview:
- Multi-master AHB bus arbiter for the FreeAHB environment. It shares one AHB slave, or the slave-side bus, between NUM_MASTERS requesting masters.
- Drives one-hot HGRANT, HMASTER and HMASTLOCK.
- Tracks burst progress so fixed-length bursts are never split and locked sequences are never interrupted.
- Sits between the master-side request lines and the address/data multiplexers feeding the slave.

Parameters:
- NUM_MASTERS, 4, number of requesters; range 2..16.
- DEFAULT_MASTER, 0, master granted when nobody requests; range 0..NUM_MASTERS-1.
- MW, $clog2(NUM_MASTERS), width of the master index (derived, not overridden).

Ports:
- i_hclk  input  1  bus clock; all state changes on posedge.
- i_hreset_n  input  1  reset, asynchronous, active-low.
- i_hbusreq  input  NUM_MASTERS  per-master bus request.
- i_hlock  input  NUM_MASTERS  per-master locked-transfer request.
- i_htrans  input  2  HTRANS of the current bus owner (muxed); IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- i_hburst  input  3  HBURST of the current owner; SINGLE=0, INCR=1, WRAP4/INCR4=2/3, WRAP8/INCR8=4/5, WRAP16/INCR16=6/7.
- i_hready  input  1  bus-wide HREADY from the slave.
- o_hgrant  output  NUM_MASTERS  one-hot grant.
- o_hmaster  output  MW  index of the master owning the address phase.
- o_hmastlock  output  1  current address phase is locked.

Behaviour:
- Reset (async assert, sync release):
  - o_hgrant = 1<<DEFAULT_MASTER.
  - o_hmaster = DEFAULT_MASTER.
  - o_hmastlock = 0.
  - Beat counter = 0; round-robin pointer = DEFAULT_MASTER.
- Beat counter (5-bit) advances only on i_hready=1:
  - NONSEQ loads 1.
  - SEQ increments.
  - IDLE clears to 0.
  - BUSY holds.
- Burst length from i_hburst: SINGLE=1, x4=4, x8=8, x16=16, INCR=undefined.
- last_beat = i_hready && htrans in {NONSEQ,SEQ} && burst fixed && cnt_next==len, where cnt_next = (NONSEQ ? 1 : cnt+1).
- arb_point (combinational) = i_hready && !lock_hold && (i_htrans==IDLE || last_beat || (i_hburst==INCR && htrans in {NONSEQ,SEQ})).
  - lock_hold = i_hlock[granted] && i_hbusreq[granted].
  - BUSY is never an arbitration point.
- At posedge with arb_point=1, o_hgrant is reloaded:
  - Round-robin search over i_hbusreq, starting at granted+1 and wrapping modulo NUM_MASTERS. The current holder is considered last.
  - No request: grant DEFAULT_MASTER.
  - Pointer updates to the new grantee.
- At posedge with arb_point=0, o_hgrant holds.
- Grant latency: a request sampled at an arb_point gives o_hgrant on the next cycle.
- o_hmaster latency: updates one cycle after o_hgrant, on the first posedge with i_hready=1. It is then set to the index of o_hgrant.
- o_hmastlock updates on that same edge, to i_hlock[granted].
- While i_hready=0, o_hmaster, o_hmastlock and the counter are frozen; o_hgrant may not change.
- Lock: a granted master holding i_hlock and i_hbusreq keeps the grant across burst ends. Release happens at the first arb_point after i_hlock drops.
- Simultaneous events:
  - The current owner's own request never blocks handover at an arb_point if another master requests (fairness).
  - Exception: if only the owner requests, it is re-granted.
- Invariant: o_hgrant is exactly one-hot in every cycle.
- Reset mid-burst: the burst is abandoned and all state returns to reset values immediately.

Optional Feature:
- AHB_ARB_FIXED_PRIO_EN defined: fixed priority; the lowest requesting index wins at every arb_point, and the round-robin pointer is removed.
- Undefined (default): round-robin as above.
- Lock and burst rules are identical in both modes.

Decomposition:
- Package ahb_pkg holds:
  - the HTRANS and HBURST localparams;
  - the HRESP codes (OKAY/ERROR/SPLIT/RETRY);
  - function burst_len(hburst) returning 0 for INCR.
- Sub-module ahb_rr_picker: combinational rotate-priority encoder.
  - Inputs: req vector and start pointer. Outputs: one-hot grant and index.
  - Under AHB_ARB_FIXED_PRIO_EN the start pointer is forced to 0.

Test Plan:
- Reset with i_hbusreq=0 -> o_hgrant=4'b0001, o_hmaster=0, o_hmastlock=0. Holding i_hreset_n low overrides all toggling inputs.
- Master 2 requests, issues INCR4 (NONSEQ + 3 SEQ), master 1 requests after beat 1 -> grant moves to 4'b0010 only after beat 4's address phase. o_hmaster=1 one ready cycle later.
- Masters 0..3 request continuously with SINGLE transfers -> grants rotate 0,1,2,3,0. The AHB_ARB_FIXED_PRIO_EN build stays on 0.
- Master 3 asserts i_hlock with two back-to-back INCR8 bursts, master 0 requesting -> no handover until i_hlock[3] drops. o_hmastlock=1 for all 16 beats.
- INCR8 with i_hready held low for 3 cycles on beat 5 and a BUSY inserted -> counter and o_hmaster frozen. Grant changes only after beat 8.
- i_hreset_n pulsed low mid-INCR16 at beat 7 -> immediate reset values. The next NONSEQ restarts the count at 1.

Source files
------------

// File: rtl/ahb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package  : ahb_pkg                                                 |
// | Purpose  : AHB transfer, burst and response encodings plus a helper |
// |            returning the beat count of a fixed-length burst.       |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
package ahb_pkg;

  localparam logic [1:0] c_htrans_idle   = 2'd0;
  localparam logic [1:0] c_htrans_busy   = 2'd1;
  localparam logic [1:0] c_htrans_nonseq = 2'd2;
  localparam logic [1:0] c_htrans_seq    = 2'd3;

  localparam logic [2:0] c_hburst_single = 3'd0;
  localparam logic [2:0] c_hburst_incr   = 3'd1;
  localparam logic [2:0] c_hburst_wrap4  = 3'd2;
  localparam logic [2:0] c_hburst_incr4  = 3'd3;
  localparam logic [2:0] c_hburst_wrap8  = 3'd4;
  localparam logic [2:0] c_hburst_incr8  = 3'd5;
  localparam logic [2:0] c_hburst_wrap16 = 3'd6;
  localparam logic [2:0] c_hburst_incr16 = 3'd7;

  localparam logic [1:0] c_hresp_okay  = 2'd0;
  localparam logic [1:0] c_hresp_error = 2'd1;
  localparam logic [1:0] c_hresp_retry = 2'd2;
  localparam logic [1:0] c_hresp_split = 2'd3;

  // Zero means "no fixed length" (undefined-length INCR).
  function automatic logic [4:0] burst_len(input logic [2:0] hburst);
    case (hburst)
      c_hburst_single:                 burst_len = 5'd1;
      c_hburst_wrap4, c_hburst_incr4:  burst_len = 5'd4;
      c_hburst_wrap8, c_hburst_incr8:  burst_len = 5'd8;
      c_hburst_wrap16, c_hburst_incr16: burst_len = 5'd16;
      default:                         burst_len = 5'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_rr_picker.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : ahb_rr_picker                                           |
// | Purpose  : Rotate-priority encoder: first set request at or after   |
// |            i_start (wrapping) wins. AHB_ARB_FIXED_PRIO_EN pins the  |
// |            start to index 0 (plain lowest-index priority).         |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module ahb_rr_picker #(
  parameter  int NUM_MASTERS = 4,
  localparam int MW          = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] i_req,
  input  logic [MW-1:0]          i_start,
  output logic [NUM_MASTERS-1:0] o_grant,
  output logic [MW-1:0]          o_idx,
  output logic                   o_valid
);

  logic [MW-1:0] w_start;
  logic          w_unused_start;
  logic [MW:0]   w_pos;
  logic          w_found;
  logic [MW-1:0] w_idx;

`ifdef AHB_ARB_FIXED_PRIO_EN
  assign w_start        = '0;
  assign w_unused_start = ^i_start;
`else
  assign w_start        = i_start;
  assign w_unused_start = 1'b0;
`endif

  // One extra bit on w_pos so start+offset can exceed NUM_MASTERS before the wrap.
  always_comb begin
    w_pos   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      w_pos = {1'b0, w_start} + (MW+1)'(i);
      if (w_pos >= (MW+1)'(NUM_MASTERS)) begin
        w_pos = w_pos - (MW+1)'(NUM_MASTERS);
      end
      if (!w_found && i_req[w_pos[MW-1:0]]) begin
        w_found = 1'b1;
        w_idx   = w_pos[MW-1:0];
      end
    end
  end

  always_comb begin
    o_grant = '0;
    if (w_found) begin
      o_grant[w_idx] = 1'b1;
    end
  end

  assign o_idx   = w_idx;
  assign o_valid = w_found;

endmodule
`default_nettype wire

// File: rtl/ahb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : ahb_arbiter                                             |
// | Purpose  : Multi-master AHB arbiter; burst-aware, lock-aware,       |
// |            round-robin by default, fixed priority when             |
// |            AHB_ARB_FIXED_PRIO_EN is defined.                       |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module ahb_arbiter
  import ahb_pkg::*;
#(
  parameter  int NUM_MASTERS    = 4,
  parameter  int DEFAULT_MASTER = 0,
  localparam int MW             = $clog2(NUM_MASTERS)
) (
  input  logic                   i_hclk,
  input  logic                   i_hreset_n,
  input  logic [NUM_MASTERS-1:0] i_hbusreq,
  input  logic [NUM_MASTERS-1:0] i_hlock,
  input  logic [1:0]             i_htrans,
  input  logic [2:0]             i_hburst,
  input  logic                   i_hready,
  output logic [NUM_MASTERS-1:0] o_hgrant,
  output logic [MW-1:0]          o_hmaster,
  output logic                   o_hmastlock
);

  if ((NUM_MASTERS < 2) || (NUM_MASTERS > 16)) begin : g_chk_num_masters
    $error("ahb_arbiter: NUM_MASTERS out of range");
  end
  if ((DEFAULT_MASTER < 0) || (DEFAULT_MASTER >= NUM_MASTERS)) begin : g_chk_default
    $error("ahb_arbiter: DEFAULT_MASTER out of range");
  end

  localparam logic [MW-1:0]          c_default_idx   = MW'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] c_default_grant = NUM_MASTERS'(1) << DEFAULT_MASTER;

  logic [NUM_MASTERS-1:0] r_grant;
  logic [MW-1:0]          r_grant_idx;
  logic [MW-1:0]          r_hmaster;
  logic                   r_hmastlock;
  logic [4:0]             r_cnt;

  logic                   w_active;
  logic [4:0]             w_len;
  logic [4:0]             w_cnt_next;
  logic                   w_last_beat;
  logic                   w_lock_hold;
  logic                   w_arb_point;
  logic [MW-1:0]          w_start;
  logic [NUM_MASTERS-1:0] w_pick_grant;
  logic [MW-1:0]          w_pick_idx;
  logic                   w_pick_valid;
  logic [NUM_MASTERS-1:0] w_next_grant;
  logic [MW-1:0]          w_next_idx;

  assign w_active    = (i_htrans == c_htrans_nonseq) || (i_htrans == c_htrans_seq);
  assign w_len       = burst_len(i_hburst);
  assign w_cnt_next  = (i_htrans == c_htrans_nonseq) ? 5'd1 : (r_cnt + 5'd1);
  assign w_last_beat = i_hready && w_active && (w_len != 5'd0) && (w_cnt_next == w_len);
  assign w_lock_hold = i_hlock[r_grant_idx] && i_hbusreq[r_grant_idx];

  // BUSY never qualifies: it is neither IDLE nor a counted beat.
  assign w_arb_point = i_hready && !w_lock_hold &&
                       ((i_htrans == c_htrans_idle) || w_last_beat ||
                        ((i_hburst == c_hburst_incr) && w_active));

`ifdef AHB_ARB_FIXED_PRIO_EN
  assign w_start = '0;
`else
  logic [MW-1:0] r_ptr;

  // The holder is searched last, so any other requester takes over first.
  assign w_start = (r_ptr == MW'(NUM_MASTERS - 1)) ? '0 : (r_ptr + MW'(1));

  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      r_ptr <= c_default_idx;
    end else if (w_arb_point) begin
      r_ptr <= w_next_idx;
    end
  end
`endif

  ahb_rr_picker #(
    .NUM_MASTERS (NUM_MASTERS)
  ) u_picker (
    .i_req   (i_hbusreq),
    .i_start (w_start),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  assign w_next_grant = w_pick_valid ? w_pick_grant : c_default_grant;
  assign w_next_idx   = w_pick_valid ? w_pick_idx   : c_default_idx;

  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      r_grant     <= c_default_grant;
      r_grant_idx <= c_default_idx;
    end else if (w_arb_point) begin
      r_grant     <= w_next_grant;
      r_grant_idx <= w_next_idx;
    end
  end

  // Address-phase ownership follows the grant on the next ready edge.
  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      r_hmaster   <= c_default_idx;
      r_hmastlock <= 1'b0;
      r_cnt       <= 5'd0;
    end else if (i_hready) begin
      r_hmaster   <= r_grant_idx;
      r_hmastlock <= i_hlock[r_grant_idx];
      case (i_htrans)
        c_htrans_idle:   r_cnt <= 5'd0;
        c_htrans_busy:   r_cnt <= r_cnt;
        c_htrans_nonseq: r_cnt <= w_cnt_next;
        c_htrans_seq:    r_cnt <= w_cnt_next;
        default:         r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_hgrant    = r_grant;
  assign o_hmaster   = r_hmaster;
  assign o_hmastlock = r_hmastlock;

endmodule
`default_nettype wire

// File: tb/tb_ahb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_ahb_arbiter                                          |
// | Purpose  : Directed scoreboard bench for ahb_arbiter (4 masters,    |
// |            default master 0); honours AHB_ARB_FIXED_PRIO_EN.       |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module tb_ahb_arbiter;

  localparam logic [1:0] c_idle   = 2'd0;
  localparam logic [1:0] c_busy   = 2'd1;
  localparam logic [1:0] c_nonseq = 2'd2;
  localparam logic [1:0] c_seq    = 2'd3;
  localparam logic [2:0] c_single = 3'd0;
  localparam logic [2:0] c_incr   = 3'd1;
  localparam logic [2:0] c_incr4  = 3'd3;
  localparam logic [2:0] c_incr8  = 3'd5;
  localparam logic [2:0] c_incr16 = 3'd7;

  logic       i_hclk = 1'b0;
  logic       i_hreset_n;
  logic [3:0] i_hbusreq;
  logic [3:0] i_hlock;
  logic [1:0] i_htrans;
  logic [2:0] i_hburst;
  logic       i_hready;
  logic [3:0] o_hgrant;
  logic [1:0] o_hmaster;
  logic       o_hmastlock;

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] master;
    logic       lock;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  always #5 i_hclk = ~i_hclk;

  ahb_arbiter #(
    .NUM_MASTERS    (4),
    .DEFAULT_MASTER (0)
  ) dut (
    .i_hclk      (i_hclk),
    .i_hreset_n  (i_hreset_n),
    .i_hbusreq   (i_hbusreq),
    .i_hlock     (i_hlock),
    .i_htrans    (i_htrans),
    .i_hburst    (i_hburst),
    .i_hready    (i_hready),
    .o_hgrant    (o_hgrant),
    .o_hmaster   (o_hmaster),
    .o_hmastlock (o_hmastlock)
  );

  task automatic push_exp(input logic [3:0] eg, input logic [1:0] em, input logic el,
                          input string tag);
    exp_t e;
    e.grant  = eg;
    e.master = em;
    e.lock   = el;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check_out();
    exp_t  e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    n_cmp++;
    assert (o_hgrant === e.grant) else begin
      n_bad++;
      $error("FAIL %s hgrant got %b want %b", t, o_hgrant, e.grant);
    end
    n_cmp++;
    assert (o_hmaster === e.master) else begin
      n_bad++;
      $error("FAIL %s hmaster got %0d want %0d", t, o_hmaster, e.master);
    end
    n_cmp++;
    assert (o_hmastlock === e.lock) else begin
      n_bad++;
      $error("FAIL %s hmastlock got %b want %b", t, o_hmastlock, e.lock);
    end
    n_cmp++;
    assert ($onehot(o_hgrant) === 1'b1) else begin
      n_bad++;
      $error("FAIL %s onehot got %b want one-hot", t, o_hgrant);
    end
  endtask

  // Drive one cycle of inputs, queue the outputs expected after that edge.
  task automatic step(input logic [3:0] req, input logic [3:0] lk, input logic [1:0] tr,
                      input logic [2:0] bu, input logic rdy,
                      input logic [3:0] eg, input logic [1:0] em, input logic el,
                      input string tag);
    i_hbusreq = req;
    i_hlock   = lk;
    i_htrans  = tr;
    i_hburst  = bu;
    i_hready  = rdy;
    push_exp(eg, em, el, tag);
    @(posedge i_hclk);
    #1;
    check_out();
  endtask

  initial begin
    i_hreset_n = 1'b0;
    i_hbusreq  = '0;
    i_hlock    = '0;
    i_htrans   = c_idle;
    i_hburst   = c_single;
    i_hready   = 1'b1;

    // Reset held low while inputs toggle.
    step(4'b1010, 4'b1111, c_nonseq, c_incr,   1'b1, 4'b0001, 2'd0, 1'b0, "rst_toggle_a");
    step(4'b0101, 4'b0000, c_seq,    c_incr16, 1'b0, 4'b0001, 2'd0, 1'b0, "rst_toggle_b");
    step(4'b1111, 4'b1000, c_idle,   c_single, 1'b1, 4'b0001, 2'd0, 1'b0, "rst_toggle_c");
    i_hreset_n = 1'b1;
    step(4'b0000, 4'b0000, c_idle, c_single, 1'b1, 4'b0001, 2'd0, 1'b0, "idle_default");

    // Master 2 INCR4, master 1 joins after beat 1.
    step(4'b0100, 4'b0000, c_idle,   c_single, 1'b1, 4'b0100, 2'd0, 1'b0, "i4_req2");
    step(4'b0100, 4'b0000, c_idle,   c_single, 1'b1, 4'b0100, 2'd2, 1'b0, "i4_own2");
    step(4'b0100, 4'b0000, c_nonseq, c_incr4,  1'b1, 4'b0100, 2'd2, 1'b0, "i4_beat1");
    step(4'b0110, 4'b0000, c_seq,    c_incr4,  1'b1, 4'b0100, 2'd2, 1'b0, "i4_beat2");
    step(4'b0110, 4'b0000, c_seq,    c_incr4,  1'b1, 4'b0100, 2'd2, 1'b0, "i4_beat3");
    step(4'b0110, 4'b0000, c_seq,    c_incr4,  1'b1, 4'b0010, 2'd2, 1'b0, "i4_beat4");
    step(4'b0010, 4'b0000, c_idle,   c_single, 1'b1, 4'b0010, 2'd1, 1'b0, "i4_own1");

    // All four request SINGLE transfers continuously.
`ifdef AHB_ARB_FIXED_PRIO_EN
    step(4'b1111, 4'b0000, c_nonseq, c_single, 1'b1, 4'b0001, 2'd1, 1'b0, "rot_1");
    step(4'b1111, 4'b0000, c_nonseq, c_single, 1'b1, 4'b0001, 2'd0, 1'b0, "rot_2");
    step(4'b1111, 4'b0000, c_nonseq, c_single, 1'b1, 4'b0001, 2'd0, 1'b0, "rot_3");
    step(4'b1111, 4'b0000, c_nonseq, c_single, 1'b1, 4'b0001, 2'd0, 1'b0, "rot_4");
    step(4'b1111, 4'b0000, c_nonseq, c_single, 1'b1, 4'b0001, 2'd0, 1'b0, "rot_5");
    step(4'b0000, 4'b0000, c_idle,   c_single, 1'b1, 4'b0001, 2'd0, 1'b0, "rot_idle_a");
`else
    step(4'b1111, 4'b0000, c_nonseq, c_single, 1'b1, 4'b0100, 2'd1, 1'b0, "rot_1");
    step(4'b1111, 4'b0000, c_nonseq, c_single, 1'b1, 4'b1000, 2'd2, 1'b0, "rot_2");
    step(4'b1111, 4'b0000, c_nonseq, c_single, 1'b1, 4'b0001, 2'd3, 1'b0, "rot_3");
    step(4'b1111, 4'b0000, c_nonseq, c_single, 1'b1, 4'b0010, 2'd0, 1'b0, "rot_4");
    step(4'b1111, 4'b0000, c_nonseq, c_single, 1'b1, 4'b0100, 2'd1, 1'b0, "rot_5");
    step(4'b0000, 4'b0000, c_idle,   c_single, 1'b1, 4'b0001, 2'd2, 1'b0, "rot_idle_a");
`endif
    step(4'b0000, 4'b0000, c_idle, c_single, 1'b1, 4'b0001, 2'd0, 1'b0, "rot_idle_b");

    // Master 3 locked across two INCR8 bursts while master 0 waits.
    step(4'b1000, 4'b1000, c_idle, c_single, 1'b1, 4'b1000, 2'd0, 1'b0, "lk_grant3");
    step(4'b1001, 4'b1000, c_idle, c_single, 1'b1, 4'b1000, 2'd3, 1'b1, "lk_own3");
    for (int b = 0; b < 2; b++) begin
      step(4'b1001, 4'b1000, c_nonseq, c_incr8, 1'b1, 4'b1000, 2'd3, 1'b1, "lk_nonseq");
      for (int k = 0; k < 7; k++) begin
        step(4'b1001, 4'b1000, c_seq, c_incr8, 1'b1, 4'b1000, 2'd3, 1'b1, "lk_seq");
      end
    end
    step(4'b0001, 4'b0000, c_idle, c_single, 1'b1, 4'b0001, 2'd3, 1'b0, "lk_release");
    step(4'b0001, 4'b0000, c_idle, c_single, 1'b1, 4'b0001, 2'd0, 1'b0, "lk_own0");

    // Master 0 INCR8 with a 3-cycle wait on beat 5 and a BUSY.
    step(4'b0101, 4'b0000, c_nonseq, c_incr8, 1'b1, 4'b0001, 2'd0, 1'b0, "i8_beat1");
    for (int k = 0; k < 3; k++) begin
      step(4'b0101, 4'b0000, c_seq, c_incr8, 1'b1, 4'b0001, 2'd0, 1'b0, "i8_beat2to4");
    end
    for (int k = 0; k < 3; k++) begin
      step(4'b0101, 4'b0000, c_seq, c_incr8, 1'b0, 4'b0001, 2'd0, 1'b0, "i8_wait");
    end
    step(4'b0101, 4'b0000, c_seq,  c_incr8, 1'b1, 4'b0001, 2'd0, 1'b0, "i8_beat5");
    step(4'b0101, 4'b0000, c_busy, c_incr8, 1'b1, 4'b0001, 2'd0, 1'b0, "i8_busy");
    step(4'b0101, 4'b0000, c_seq,  c_incr8, 1'b1, 4'b0001, 2'd0, 1'b0, "i8_beat6");
    step(4'b0101, 4'b0000, c_seq,  c_incr8, 1'b1, 4'b0001, 2'd0, 1'b0, "i8_beat7");
    step(4'b0100, 4'b0000, c_seq,  c_incr8, 1'b1, 4'b0100, 2'd0, 1'b0, "i8_beat8");
    step(4'b0100, 4'b0000, c_idle, c_single, 1'b0, 4'b0100, 2'd0, 1'b0, "i8_hm_frz_a");
    step(4'b0100, 4'b0000, c_idle, c_single, 1'b0, 4'b0100, 2'd0, 1'b0, "i8_hm_frz_b");
    step(4'b0100, 4'b0000, c_idle, c_single, 1'b1, 4'b0100, 2'd2, 1'b0, "i8_own2");

    // Master 2 INCR16 interrupted by reset at beat 7.
    step(4'b0110, 4'b0000, c_nonseq, c_incr16, 1'b1, 4'b0100, 2'd2, 1'b0, "i16_beat1");
    for (int k = 0; k < 6; k++) begin
      step(4'b0110, 4'b0000, c_seq, c_incr16, 1'b1, 4'b0100, 2'd2, 1'b0, "i16_seq");
    end
    #1;
    i_hreset_n = 1'b0;
    push_exp(4'b0001, 2'd0, 1'b0, "rst_async_now");
    #2;
    check_out();
    push_exp(4'b0001, 2'd0, 1'b0, "rst_held_edge");
    @(posedge i_hclk);
    #1;
    check_out();
    i_hreset_n = 1'b1;

    step(4'b0010, 4'b0000, c_idle,   c_single, 1'b1, 4'b0010, 2'd0, 1'b0, "post_req1");
    step(4'b0010, 4'b0000, c_idle,   c_single, 1'b1, 4'b0010, 2'd1, 1'b0, "post_own1");
    step(4'b0011, 4'b0000, c_nonseq, c_incr4,  1'b1, 4'b0010, 2'd1, 1'b0, "post_beat1");
    step(4'b0011, 4'b0000, c_seq,    c_incr4,  1'b1, 4'b0010, 2'd1, 1'b0, "post_beat2");
    step(4'b0011, 4'b0000, c_seq,    c_incr4,  1'b1, 4'b0010, 2'd1, 1'b0, "post_beat3");
    step(4'b0011, 4'b0000, c_seq,    c_incr4,  1'b1, 4'b0001, 2'd1, 1'b0, "post_beat4");
    step(4'b0001, 4'b0000, c_idle,   c_single, 1'b1, 4'b0001, 2'd0, 1'b0, "post_own0");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
